// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, ALU select codes, sequencer state encoding
// and the decoded-instruction record passed from op_decode to the sequencer.
package cpu_defs;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NOP  = 5'h1A;
  localparam logic [4:0] OP_HALT = 5'h1B;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;
  localparam logic [3:0] ALU_DIV = 4'h5;
  localparam logic [3:0] ALU_INC = 4'h6;

  // State encoding is visible on state_dbg, so the values are fixed.
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_T0     = 4'd1;
  localparam logic [3:0] ST_T1     = 4'd2;
  localparam logic [3:0] ST_T2     = 4'd3;
  localparam logic [3:0] ST_T3     = 4'd4;
  localparam logic [3:0] ST_T4     = 4'd5;
  localparam logic [3:0] ST_T5     = 4'd6;
  localparam logic [3:0] ST_T6     = 4'd7;
  localparam logic [3:0] ST_HALTED = 4'd8;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       is_alu;
    logic       is_muldiv;
    logic       is_nop;
    logic       is_halt;
  } decode_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder. Any opcode that is not an ALU, MUL/DIV or
// HALT instruction is reported as a NOP.
module op_decode
  import cpu_defs::*;
(
  input  logic [4:0] opcode,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD: begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND: begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR;  end
      OP_MUL: begin dec.is_muldiv = 1'b1; dec.alu_op = ALU_MUL; end
      OP_DIV: begin dec.is_muldiv = 1'b1; dec.alu_op = ALU_DIV; end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch in T0-T2, execute in T3-T6,
// one state per clock, Moore strobes decoded from the registered state.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic            mem_rdy,
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [ALUW-1:0] alu_op,
  output logic            instr_done,
  output logic            halted,
  output logic [3:0]      state_dbg
);

  logic [3:0]     state;
  logic [3:0]     state_next;
  logic           t1_first;
  logic [OPW-1:0] opcode;
  decode_t        dec;
  decode_t        op_q;
  logic [3:0]     boundary;
  logic           unused_ir;

  assign opcode    = ir[31:32-OPW];
  assign unused_ir = ^ir[31-OPW:0];
  assign state_dbg = state;

  op_decode u_op_decode (
    .opcode (5'(opcode)),
    .dec    (dec)
  );

  // Instruction boundary: an instruction always runs to completion, and
  // run is only consulted here, on the way back to T0.
  assign boundary = run ? ST_T0 : ST_IDLE;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (run) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1:   if (mem_rdy) state_next = ST_T2;
      ST_T2:   state_next = ST_T3;
      ST_T3: begin
        if (dec.is_halt)                       state_next = ST_HALTED;
        else if (dec.is_alu || dec.is_muldiv)  state_next = ST_T4;
        else                                   state_next = boundary;
      end
      ST_T4:     state_next = ST_T5;
      ST_T5:     state_next = op_q.is_muldiv ? ST_T6 : boundary;
      ST_T6:     state_next = boundary;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_IDLE;
    endcase
  end

  // t1_first marks the first T1 cycle so PCin fires once even when memory
  // stalls; op_q freezes the decode at T3 so later IR changes are harmless.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE;
      t1_first <= 1'b0;
      op_q     <= '0;
    end else begin
      state    <= state_next;
      t1_first <= (state == ST_T0);
      if (state == ST_T3) op_q <= dec;
    end
  end

  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        alu_op = ALUW'(ALU_INC);
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = t1_first;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (dec.is_alu || dec.is_muldiv) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else begin
          instr_done = 1'b1;
        end
      end
      ST_T4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = ALUW'(op_q.alu_op);
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (op_q.is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra        = 1'b1;
          Rin        = 1'b1;
          instr_done = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: per-cycle state and
// strobe checks for each instruction class, stalls, halt, reset and run drop.
module tb_control_sequencer;
  import cpu_defs::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic        mem_rdy;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin;
  logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, instr_done, halted;
  logic [3:0]  alu_op;
  logic [3:0]  state_dbg;
  logic [20:0] obs;
  logic        monitor_on = 1'b0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [20:0] S_PCOUT = 21'(1) << 20;
  localparam logic [20:0] S_ZLO   = 21'(1) << 19;
  localparam logic [20:0] S_ZHI   = 21'(1) << 18;
  localparam logic [20:0] S_MDRO  = 21'(1) << 17;
  localparam logic [20:0] S_MARIN = 21'(1) << 16;
  localparam logic [20:0] S_PCIN  = 21'(1) << 15;
  localparam logic [20:0] S_MDRIN = 21'(1) << 14;
  localparam logic [20:0] S_IRIN  = 21'(1) << 13;
  localparam logic [20:0] S_YIN   = 21'(1) << 12;
  localparam logic [20:0] S_ZIN   = 21'(1) << 11;
  localparam logic [20:0] S_HIIN  = 21'(1) << 10;
  localparam logic [20:0] S_LOIN  = 21'(1) << 9;
  localparam logic [20:0] S_INC   = 21'(1) << 8;
  localparam logic [20:0] S_READ  = 21'(1) << 7;
  localparam logic [20:0] S_GRA   = 21'(1) << 6;
  localparam logic [20:0] S_GRB   = 21'(1) << 5;
  localparam logic [20:0] S_GRC   = 21'(1) << 4;
  localparam logic [20:0] S_RIN   = 21'(1) << 3;
  localparam logic [20:0] S_ROUT  = 21'(1) << 2;
  localparam logic [20:0] S_DONE  = 21'(1) << 1;
  localparam logic [20:0] S_HALT  = 21'(1) << 0;

  localparam logic [20:0] E_T0  = S_PCOUT | S_MARIN | S_INC | S_ZIN;
  localparam logic [20:0] E_T1F = S_ZLO | S_PCIN | S_READ | S_MDRIN;
  localparam logic [20:0] E_T1W = S_ZLO | S_READ | S_MDRIN;
  localparam logic [20:0] E_T2  = S_MDRO | S_IRIN;
  localparam logic [20:0] E_T3R = S_GRB | S_ROUT | S_YIN;
  localparam logic [20:0] E_T3D = S_DONE;
  localparam logic [20:0] E_T4  = S_GRC | S_ROUT | S_ZIN;
  localparam logic [20:0] E_T5A = S_ZLO | S_GRA | S_RIN | S_DONE;
  localparam logic [20:0] E_T5M = S_ZLO | S_LOIN;
  localparam logic [20:0] E_T6  = S_ZHI | S_HIIN | S_DONE;
  localparam logic [20:0] E_HLT = S_HALT;

  localparam logic [31:0] IR_ADD  = 32'h0089_8000;
  localparam logic [31:0] IR_MUL  = 32'h7800_0000;
  localparam logic [31:0] IR_DIV  = 32'h8000_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_UNL  = 32'h3800_0000;

  always #5 clock = ~clock;

  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
                HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, instr_done, halted};

  control_sequencer #(.OPW(5), .ALUW(4)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_rdy(mem_rdy), .ir(ir),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .instr_done(instr_done),
    .halted(halted), .state_dbg(state_dbg)
  );

  // At most one bus driver may be active in any cycle.
  always @(negedge clock) begin
    if (monitor_on) begin
      checks++;
      if ($countones({PCout, Zlowout, Zhighout, MDRout, Rout}) > 1) begin
        errors++;
        $display("[TB] FAIL bus_invariant at %0t: drivers=%b, want at most one high",
                 $time, {PCout, Zlowout, Zhighout, MDRout, Rout});
      end
    end
  end

  task automatic do_reset();
    clear   = 1'b0;
    run     = 1'b0;
    mem_rdy = 1'b1;
    ir      = 32'h0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b0;
    run   = 1'b1;
    #1;
    checks++;
    if (state_dbg !== ST_IDLE || obs !== 21'h0 || alu_op !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: state=%0d strobes=%h alu_op=%h, want 0/0/0",
               state_dbg, obs, alu_op);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (state_dbg !== ST_IDLE || obs !== 21'h0) begin
      errors++;
      $display("[TB] FAIL reset_hold: state=%0d strobes=%h, want 0/0", state_dbg, obs);
    end
    do_reset();
  endtask

  task automatic test_add();
    logic [3:0]  es [7] = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T0};
    logic [20:0] eo [7] = '{E_T0, E_T1F, E_T2, E_T3R, E_T4, E_T5A, E_T0};
    do_reset();
    ir  = IR_ADD;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL add step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
      if (i == 4) begin
        checks++;
        if (alu_op !== ALU_ADD) begin
          errors++;
          $display("[TB] FAIL add alu_op: got %h, want %h", alu_op, ALU_ADD);
        end
      end
    end
    run = 1'b0;
  endtask

  task automatic test_mul();
    logic [3:0]  es [8] = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T0};
    logic [20:0] eo [8] = '{E_T0, E_T1F, E_T2, E_T3R, E_T4, E_T5M, E_T6, E_T0};
    do_reset();
    ir  = IR_MUL;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL mul step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
      if (i == 4) begin
        checks++;
        if (alu_op !== ALU_MUL) begin
          errors++;
          $display("[TB] FAIL mul alu_op: got %h, want %h", alu_op, ALU_MUL);
        end
        ir = IR_ADD;
      end
    end
    run = 1'b0;
  endtask

  task automatic test_mem_wait();
    logic [3:0]  es [7] = '{ST_T0, ST_T1, ST_T1, ST_T1, ST_T1, ST_T2, ST_T3};
    logic [20:0] eo [7] = '{E_T0, E_T1F, E_T1W, E_T1W, E_T1W, E_T2, E_T3R};
    do_reset();
    ir      = IR_ADD;
    mem_rdy = 1'b0;
    run     = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL mem_wait step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
      if (i == 4) mem_rdy = 1'b1;
    end
    run = 1'b0;
  endtask

  task automatic test_nop();
    logic [3:0]  es [9] = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T0, ST_T1, ST_T2, ST_T3, ST_T0};
    logic [20:0] eo [9] = '{E_T0, E_T1F, E_T2, E_T3D, E_T0, E_T1F, E_T2, E_T3D, E_T0};
    do_reset();
    ir  = IR_UNL;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL nop step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
      if (i == 3) ir = IR_NOP;
    end
    run = 1'b0;
  endtask

  task automatic test_halt();
    logic [3:0]  es [4] = '{ST_T0, ST_T1, ST_T2, ST_T3};
    logic [20:0] eo [4] = '{E_T0, E_T1F, E_T2, E_T3D};
    do_reset();
    ir  = IR_HALT;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL halt step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== ST_HALTED || obs !== E_HLT) begin
        errors++;
        $display("[TB] FAIL halted cycle %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, ST_HALTED, E_HLT);
      end
      run = ~run;
    end
    run = 1'b0;
  endtask

  task automatic test_clear_mid();
    logic [3:0]  es [5] = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4};
    logic [20:0] eo [5] = '{E_T0, E_T1F, E_T2, E_T3R, E_T4};
    do_reset();
    ir  = IR_DIV;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL clear_mid step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
    end
    checks++;
    if (alu_op !== ALU_DIV) begin
      errors++;
      $display("[TB] FAIL div alu_op: got %h, want %h", alu_op, ALU_DIV);
    end
    #2 clear = 1'b0;
    #1;
    checks++;
    if (state_dbg !== ST_IDLE || obs !== 21'h0 || alu_op !== 4'h0) begin
      errors++;
      $display("[TB] FAIL async_clear: state=%0d strobes=%h alu_op=%h, want 0/0/0",
               state_dbg, obs, alu_op);
    end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    checks++;
    if (state_dbg !== ST_T0 || obs !== E_T0) begin
      errors++;
      $display("[TB] FAIL restart: state=%0d strobes=%h, want state=%0d strobes=%h",
               state_dbg, obs, ST_T0, E_T0);
    end
    run = 1'b0;
  endtask

  task automatic test_run_drop();
    logic [3:0]  es [9] = '{ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_IDLE, ST_IDLE, ST_T0};
    logic [20:0] eo [9] = '{E_T0, E_T1F, E_T2, E_T3R, E_T4, E_T5A, 21'h0, 21'h0, E_T0};
    do_reset();
    ir  = IR_ADD;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      checks++;
      if (state_dbg !== es[i] || obs !== eo[i]) begin
        errors++;
        $display("[TB] FAIL run_drop step %0d: state=%0d strobes=%h, want state=%0d strobes=%h",
                 i, state_dbg, obs, es[i], eo[i]);
      end
      if (i == 2) run = 1'b0;
      if (i == 7) run = 1'b1;
    end
    run = 1'b0;
  endtask

  initial begin
    clear      = 1'b0;
    run        = 1'b0;
    mem_rdy    = 1'b1;
    ir         = 32'h0;
    monitor_on = 1'b1;
    test_reset();
    test_add();
    test_mul();
    test_mem_wait();
    test_nop();
    test_halt();
    test_clear_mid();
    test_run_drop();
    monitor_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
